mbox_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the single mailbox write channel among NUM_REQ producer ports. It sits in front of the mailbox skid-buffer stage and forwards one beat per cycle into a registered output slot. When the lock feature is compiled in, it keeps a multi-beat message from one requester contiguous and forces a cut when a message runs past MAX_MSG_LEN beats.

---
 rtl/mbox_pkg.sv | 17 +
 rtl/mbox_rr_pick.sv | 29 ++
 rtl/mbox_rr_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mbox_rr_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbox_pkg.sv
// rtl/mbox_pkg.sv - shared types, defaults and helpers for the mailbox write-channel arbiter
package mbox_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   localparam int MBOX_NUM_REQ     = 4;
   localparam int MBOX_MAX_MSG_LEN = 16;

   // Index width for n requesters; a single requester still needs one bit.
   function automatic int mbox_id_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mbox_rr_pick.sv
// rtl/mbox_rr_pick.sv - combinational rotating priority encoder
// Searches upward from ptr_i+1 (wrapping) for the first asserted request.
module mbox_rr_pick
   import mbox_pkg::*;
#(
   parameter int NUM_REQ = MBOX_NUM_REQ,
   parameter int ID_W    = mbox_id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic               grant_valid_o,
   output logic [ID_W-1:0]    grant_idx_o
);

   always_comb begin : pick_p
      int idx;
      idx           = 0;
      grant_valid_o = 1'b0;
      grant_idx_o   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr_i) + k) % NUM_REQ;
         if (!grant_valid_o && req_i[ID_W'(idx)]) begin
            grant_valid_o = 1'b1;
            grant_idx_o   = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/mbox_rr_arbiter.sv
// rtl/mbox_rr_arbiter.sv - round-robin arbiter feeding the mailbox write channel slot
// Define MBOX_ARB_LOCK_EN to keep messages contiguous with a MAX_MSG_LEN forced cut.
module mbox_rr_arbiter
   import mbox_pkg::*;
#(
   parameter  int NUM_REQ     = MBOX_NUM_REQ,
   parameter  int DATA_WIDTH  = 32,
   parameter  int MAX_MSG_LEN = MBOX_MAX_MSG_LEN,
   localparam int ID_W        = mbox_id_w(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ-1:0]            req_last_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [DATA_WIDTH-1:0]         out_data_o,
   output logic                          out_last_o,
   output logic [ID_W-1:0]               out_src_o,
   output logic                          trunc_o,
   output logic                          busy_o
);

   if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_MSG_LEN < 2 || MAX_MSG_LEN > 256) begin : g_param_check
      $error("mbox_rr_arbiter: NUM_REQ or MAX_MSG_LEN out of range");
   end

   logic                  out_valid_q;
   logic                  out_last_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic [ID_W-1:0]       out_src_q;
   logic [ID_W-1:0]       ptr_q, ptr_d;

   logic                  load_ok;
   logic                  pick_valid;
   logic [ID_W-1:0]       pick_idx;
   logic                  grant_valid;
   logic [ID_W-1:0]       grant_idx;
   logic                  sel_valid;
   logic                  sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  accept;
   logic                  cut;

   assign load_ok = !out_valid_q || out_ready_i;

   mbox_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req_i         (req_valid_i),
      .ptr_i         (ptr_q),
      .grant_valid_o (pick_valid),
      .grant_idx_o   (pick_idx)
   );

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            sel_valid = req_valid_i[i];
            sel_last  = req_last_i[i];
            sel_data  = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Ready is gated by rst so nothing is handed over while the slot is held in reset.
   always_comb begin
      req_ready_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready_o[i] = !rst && load_ok && grant_valid && (grant_idx == ID_W'(i));
      end
   end

   assign accept = load_ok && grant_valid && sel_valid;

`ifdef MBOX_ARB_LOCK_EN
   localparam int CNT_W = $clog2(MAX_MSG_LEN + 1);

   arb_state_e       state_q, state_d;
   logic [ID_W-1:0]  owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             trunc_q;

   assign grant_valid = (state_q == ARB_LOCKED) ? 1'b1    : pick_valid;
   assign grant_idx   = (state_q == ARB_LOCKED) ? owner_q : pick_idx;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      cut     = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (accept) begin
               if (sel_last) begin
                  ptr_d = grant_idx;
               end else begin
                  state_d = ARB_LOCKED;
                  owner_d = grant_idx;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         ARB_LOCKED: begin
            // cnt_q counts beats already taken, so this beat is number cnt_q+1.
            if (accept) begin
               if (sel_last || cnt_q == CNT_W'(MAX_MSG_LEN - 1)) begin
                  cut     = !sel_last;
                  state_d = ARB_IDLE;
                  ptr_d   = owner_q;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         owner_q <= '0;
         cnt_q   <= '0;
         trunc_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         trunc_q <= cut;
      end
   end

   assign trunc_o = trunc_q;
   assign busy_o  = (state_q == ARB_LOCKED) || out_valid_q;
`else
   assign grant_valid = pick_valid;
   assign grant_idx   = pick_idx;
   assign cut         = 1'b0;
   assign ptr_d       = accept ? grant_idx : ptr_q;
   assign trunc_o     = 1'b0;
   assign busy_o      = out_valid_q;
`endif

   // A load in the same cycle as a drain simply overwrites the slot, so there is no bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         ptr_q       <= ID_W'(NUM_REQ - 1);
      end else begin
         if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_src_q   <= grant_idx;
            out_last_q  <= sel_last | cut;
         end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
         end
         ptr_q <= ptr_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_last_o  = out_last_q;
   assign out_src_o   = out_src_q;

endmodule

// File: tb/tb_mbox_rr_arbiter.sv
// tb/tb_mbox_rr_arbiter.sv - scoreboard bench for mbox_rr_arbiter
module tb_mbox_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int ML = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_valid_i = '0;
   logic [N-1:0]    req_last_i = '0;
   logic [N*DW-1:0] req_data_i = '0;
   logic [N-1:0]    req_ready_o;
   logic            out_valid_o;
   logic            out_ready_i = 1'b1;
   logic [DW-1:0]   out_data_o;
   logic            out_last_o;
   logic [1:0]      out_src_o;
   logic            trunc_o;
   logic            busy_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mbox_rr_arbiter #(
      .NUM_REQ     (N),
      .DATA_WIDTH  (DW),
      .MAX_MSG_LEN (ML)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid_i),
      .req_last_i  (req_last_i),
      .req_data_i  (req_data_i),
      .req_ready_o (req_ready_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_last_o  (out_last_o),
      .out_src_o   (out_src_o),
      .trunc_o     (trunc_o),
      .busy_o      (busy_o)
   );

   typedef struct packed {
      logic [1:0]    src;
      logic [DW-1:0] data;
      logic          last;
      logic          trunc;
   } beat_t;

   logic [DW:0] rmem [N][64];
   int          rhead   [N] = '{0, 0, 0, 0};
   int          rtail   [N] = '{0, 0, 0, 0};
   int          skip_to [N] = '{0, 0, 0, 0};
   logic [N-1:0] hs_q = '0;
   beat_t       exp_q [$];
   logic        mon_en = 1'b0;
   logic        mon_hs = 1'b0;
   beat_t       mon_b;
   beat_t       mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] dat(input int i, input int b);
      return 32'hA500_0000 + 32'(i * 256 + b);
   endfunction

   task automatic send(input int i, input int b, input logic last);
      rmem[i][rtail[i]] = {last, dat(i, b)};
      rtail[i] = rtail[i] + 1;
   endtask

   task automatic expect_beat(input int src, input int b, input logic last, input logic tr);
      exp_q.push_back({2'(src), dat(src, b), last, tr});
   endtask

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   function automatic logic pending();
      logic p;
      p = 1'b0;
      for (int i = 0; i < N; i++) if (rhead[i] < rtail[i]) p = 1'b1;
      return p;
   endfunction

   task automatic wait_drain(input string name, output int n);
      n = 0;
      while ((exp_q.size() != 0 || pending() || busy_o) && n < 80) begin
         tick();
         n++;
      end
      chk({name, "_drained"}, 64'(exp_q.size() != 0 || pending() || busy_o), 64'(0));
   endtask

   // Requester model: present the head beat of each port's list, advance on handshake.
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (hs_q[i]) rhead[i] = rhead[i] + 1;
         if (rhead[i] < skip_to[i]) rhead[i] = skip_to[i];
         if (rhead[i] < rtail[i]) begin
            req_valid_i[i]          = 1'b1;
            req_last_i[i]           = rmem[i][rhead[i]][DW];
            req_data_i[i*DW +: DW]  = rmem[i][rhead[i]][DW-1:0];
         end else begin
            req_valid_i[i]          = 1'b0;
            req_last_i[i]           = 1'b0;
            req_data_i[i*DW +: DW]  = '0;
         end
      end
   end

   always @(posedge clk) begin
      hs_q   <= req_valid_i & req_ready_o;
      mon_hs <= mon_en && out_valid_o && out_ready_i;
      mon_b  <= {out_src_o, out_data_o, out_last_o, trunc_o};
   end

   always @(negedge clk) begin
      if (mon_hs) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got src %0d data %h, none expected", mon_b.src, mon_b.data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("beat_src",   64'(mon_b.src),   64'(mon_e.src));
            chk("beat_data",  64'(mon_b.data),  64'(mon_e.data));
            chk("beat_last",  64'(mon_b.last),  64'(mon_e.last));
            chk("beat_trunc", 64'(mon_b.trunc), 64'(mon_e.trunc));
         end
      end
   end

   initial begin
      int n;
      tick();
      tick();
      chk("rst_valid", 64'(out_valid_o), 64'(0));
      chk("rst_data",  64'(out_data_o),  64'(0));
      chk("rst_last",  64'(out_last_o),  64'(0));
      chk("rst_src",   64'(out_src_o),   64'(0));
      chk("rst_trunc", 64'(trunc_o),     64'(0));
      chk("rst_busy",  64'(busy_o),      64'(0));
      send(1, 9, 1'b1);
      tick();
      tick();
      chk("rst_ready", 64'(req_ready_o), 64'(0));

      // Load the slot, then reset mid-stream: everything clears without waiting for a clock.
      rst = 1'b0;
      n = 0;
      while (!out_valid_o && n < 20) begin
         tick();
         n++;
      end
      chk("pre_rst_loaded", 64'(out_valid_o), 64'(1));
      rst = 1'b1;
      #1;
      chk("midrst_valid", 64'(out_valid_o), 64'(0));
      chk("midrst_data",  64'(out_data_o),  64'(0));
      chk("midrst_src",   64'(out_src_o),   64'(0));
      chk("midrst_last",  64'(out_last_o),  64'(0));
      chk("midrst_busy",  64'(busy_o),      64'(0));
      chk("midrst_ready", 64'(req_ready_o), 64'(0));
      for (int i = 0; i < N; i++) skip_to[i] = rtail[i];
      tick();
      tick();
      rst = 1'b0;
      mon_en = 1'b1;

      // Fairness: every port valid with single-beat messages, requester 0 first after reset.
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < N; i++) begin
            send(i, b, 1'b1);
            expect_beat(i, b, 1'b1, 1'b0);
         end
      end
      wait_drain("fair", n);
      chk("fair_rate", 64'(n <= 11), 64'(1));

`ifdef MBOX_ARB_LOCK_EN
      // Lock: requester 2 holds the channel for its 3-beat message.
      for (int b = 0; b < 3; b++) send(2, b, b == 2);
      n = 0;
      while (rhead[2] < 1 && n < 20) begin
         tick();
         n++;
      end
      chk("lock_first_taken", 64'(rhead[2] >= 1), 64'(1));
      send(0, 0, 1'b1);
      send(1, 0, 1'b1);
      expect_beat(2, 0, 1'b0, 1'b0);
      expect_beat(2, 1, 1'b0, 1'b0);
      expect_beat(2, 2, 1'b1, 1'b0);
      expect_beat(0, 0, 1'b1, 1'b0);
      expect_beat(1, 0, 1'b1, 1'b0);
      wait_drain("lock", n);

      // Truncation: 6-beat message cut after beat 4, remainder is a new message.
      for (int b = 0; b < 6; b++) send(1, b, b == 5);
      expect_beat(1, 0, 1'b0, 1'b0);
      expect_beat(1, 1, 1'b0, 1'b0);
      expect_beat(1, 2, 1'b0, 1'b0);
      expect_beat(1, 3, 1'b1, 1'b1);
      expect_beat(1, 4, 1'b0, 1'b0);
      expect_beat(1, 5, 1'b1, 1'b0);
      wait_drain("trunc", n);
`else
      // Without locking, multi-beat messages interleave beat by beat.
      for (int b = 0; b < 3; b++) begin
         send(0, b, b == 2);
         send(1, b, b == 2);
         expect_beat(0, b, b == 2, 1'b0);
         expect_beat(1, b, b == 2, 1'b0);
      end
      wait_drain("interleave", n);
`endif

      // Backpressure: slot holds steady, nobody is granted, then drain and load coincide.
      out_ready_i = 1'b0;
      send(2, 7, 1'b1);
      send(3, 7, 1'b1);
      expect_beat(2, 7, 1'b1, 1'b0);
      expect_beat(3, 7, 1'b1, 1'b0);
      n = 0;
      while (!out_valid_o && n < 20) begin
         tick();
         n++;
      end
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("bp_valid", 64'(out_valid_o), 64'(1));
         chk("bp_src",   64'(out_src_o),   64'(2));
         chk("bp_data",  64'(out_data_o),  64'(dat(2, 7)));
         chk("bp_last",  64'(out_last_o),  64'(1));
         chk("bp_ready", 64'(req_ready_o), 64'(0));
      end
      out_ready_i = 1'b1;
      #1;
      chk("bp_release_ready", 64'(req_ready_o), 64'(4'b1000));
      wait_drain("bp", n);

      chk("end_valid", 64'(out_valid_o), 64'(0));
      chk("end_busy",  64'(busy_o),      64'(0));
      chk("end_trunc", 64'(trunc_o),     64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
